// File: rtl/mul_pkg.sv
// Shared encodings for the iterative LEGv8 multiplier: operation codes,
// FSM states and the zero-register number.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_SMULH = 2'b01,
    OP_UMULH = 2'b10
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_WB   = 2'b11
  } mul_state_e;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/mul_unit_if.sv
// Request/result bundle between the execute stage and the multiplier;
// the result side feeds the regfile write port directly.
interface mul_unit_if #(parameter int WIDTH = 64);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       rd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       WriteRegister;
  logic             RegWrite;

  modport master (
    output start, op, a, b, rd,
    input  busy, done, WriteData, WriteRegister, RegWrite
  );

  modport slave (
    input  start, op, a, b, rd,
    output busy, done, WriteData, WriteRegister, RegWrite
  );
endinterface

// File: rtl/mul_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into
// the upper product half, then shift {carry, product} right by one.
module mul_shift_add_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] product,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               mplierLsb,
  output logic [2*WIDTH-1:0] nextProduct
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gAddend
      assign addend[gi] = multiplicand[gi] & mplierLsb;
    end
  endgenerate

  // The carry out of the add becomes the new MSB after the shift.
  assign sum         = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign nextProduct = (2*WIDTH)'({sum, product[WIDTH-1:0]} >> 1);

endmodule

// File: rtl/mul_unit.sv
// Iterative 64x64 multiplier for MUL/SMULH/UMULH. Signed operation runs on
// magnitudes and negates the 128-bit product once before writeback.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic        clk,
  input logic        reset,
  mul_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_e         stateReg;
  logic [1:0]         opReg;
  logic [4:0]         rdReg;
  logic               negReg;
  logic [WIDTH-1:0]   mcandReg;
  logic [WIDTH-1:0]   mplierReg;
  logic [2*WIDTH-1:0] productReg;
  logic [CNT_W-1:0]   cntReg;
  logic               busyReg;
  logic               doneReg;
  logic               regWriteReg;
  logic [WIDTH-1:0]   writeDataReg;
  logic [4:0]         writeRegReg;

  logic               isSigned;
  logic               opHigh;
  logic [WIDTH-1:0]   aAbs;
  logic [WIDTH-1:0]   bAbs;
  logic [2*WIDTH-1:0] stepProduct;
  logic [2*WIDTH-1:0] fixedProduct;

  // 2^63 has no positive signed form but fits exactly as an unsigned magnitude.
  assign isSigned     = (bus.op == OP_SMULH);
  assign aAbs         = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign bAbs         = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign opHigh       = (opReg == OP_SMULH) || (opReg == OP_UMULH);
  assign fixedProduct = negReg ? -productReg : productReg;

  mul_shift_add_step #(.WIDTH(WIDTH)) uStep (
    .product      (productReg),
    .multiplicand (mcandReg),
    .mplierLsb    (mplierReg[0]),
    .nextProduct  (stepProduct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= S_IDLE;
      opReg        <= '0;
      rdReg        <= '0;
      negReg       <= 1'b0;
      mcandReg     <= '0;
      mplierReg    <= '0;
      productReg   <= '0;
      cntReg       <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      regWriteReg  <= 1'b0;
      writeDataReg <= '0;
      writeRegReg  <= '0;
    end else begin
      doneReg     <= 1'b0;
      regWriteReg <= 1'b0;
      case (stateReg)
        S_IDLE: begin
          if (bus.start) begin
            opReg      <= bus.op;
            rdReg      <= bus.rd;
            mcandReg   <= isSigned ? aAbs : bus.a;
            mplierReg  <= isSigned ? bAbs : bus.b;
            negReg     <= isSigned & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            productReg <= '0;
            cntReg     <= '0;
            busyReg    <= 1'b1;
            stateReg   <= S_CALC;
          end
        end
        S_CALC: begin
          productReg <= stepProduct;
          mplierReg  <= mplierReg >> 1;
          cntReg     <= cntReg + 1'b1;
          if (cntReg == LAST_ITER) stateReg <= S_FIX;
        end
        S_FIX: begin
          productReg   <= fixedProduct;
          writeDataReg <= opHigh ? fixedProduct[2*WIDTH-1:WIDTH] : fixedProduct[WIDTH-1:0];
          writeRegReg  <= rdReg;
          doneReg      <= 1'b1;
          regWriteReg  <= (rdReg != XZR);
          stateReg     <= S_WB;
        end
        S_WB: begin
          busyReg  <= 1'b0;
          stateReg <= S_IDLE;
        end
        default: stateReg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = busyReg;
  assign bus.done          = doneReg;
  assign bus.RegWrite      = regWriteReg;
  assign bus.WriteData     = writeDataReg;
  assign bus.WriteRegister = writeRegReg;

endmodule

// File: tb/tb_mul_unit.sv
// Table-driven bench for mul_unit with a result scoreboard and a small
// regfile model sampling the write port.
module tb_mul_unit;
  import mul_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[9];
  logic [63:0] rf [32] = '{default: '0};

  mul_unit_if #(.WIDTH(64)) bus ();

  mul_unit #(.WIDTH(64), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RegWrite) rf[bus.WriteRegister] <= bus.WriteData;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic signed [127:0] sa, sb2, sp;
    logic [127:0] up;
    sa  = {{64{a[63]}}, a};
    sb2 = {{64{b[63]}}, b};
    sp  = sa * sb2;
    up  = {64'd0, a} * {64'd0, b};
    case (op)
      2'b01:   return sp[127:64];
      2'b10:   return up[127:64];
      default: return up[63:0];
    endcase
  endfunction

  // Issue one request and watch 68 cycles: latency, pulse counts, scoreboard data.
  task automatic runOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp, input bit interfere);
    int doneN = 0, doneCnt = 0, rwCnt = 0, busyCnt = 0;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd = rd;
    sb.push_back('{data: exp, rd: rd});
    for (int n = 1; n <= 68; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.op = 2'($urandom); bus.rd = 5'($urandom);
      end
      if (interfere && n == 11) begin
        bus.start = 1'b1; bus.a = 64'd1000; bus.b = 64'd3; bus.op = 2'b00; bus.rd = rd ^ 5'd1;
      end
      if (interfere && n == 12) bus.start = 1'b0;
      if (bus.busy) busyCnt++;
      if (bus.RegWrite) rwCnt++;
      if (bus.done) begin
        doneCnt++;
        if (doneN == 0) doneN = n;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("WriteData", bus.WriteData, e.data);
          check("WriteRegister", 64'(bus.WriteRegister), 64'(e.rd));
          check("RegWrite_in_wb", 64'(bus.RegWrite), 64'(e.rd != XZR));
        end
      end
    end
    check("done_latency", 64'(doneN), 64'd66);
    check("done_pulses", 64'(doneCnt), 64'd1);
    check("busy_cycles", 64'(busyCnt), 64'd66);
    check("regwrite_pulses", 64'(rwCnt), 64'(rd != XZR));
    $display("txn op=%0d a=%h b=%h rd=%0d exp=%h got=%h", op, a, b, rd, exp, bus.WriteData);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    int rwCnt, doneCnt;

    vecs[0] = '{2'b00, 64'd3, 64'd5, 5'd2, 64'h0F};
    vecs[1] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd0};
    vecs[3] = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd5,
                64'h4000_0000_0000_0000};
    vecs[4] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
                64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd1};
    vecs[6] = '{2'b11, 64'd6, 64'd7, 5'd8, 64'd42};
    vecs[7] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8] = '{2'b00, 64'd7, 64'd9, 5'd31, 64'd63};

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_RegWrite", 64'(bus.RegWrite), 64'd0);
    check("reset_WriteData", bus.WriteData, 64'd0);
    check("reset_WriteRegister", 64'(bus.WriteRegister), 64'd0);

    for (int i = 0; i < 9; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b0);
    check("rf_x2", rf[2], 64'h0F);
    check("rf_x6", rf[6], 64'hFFFF_FFFF_FFFF_FFFE);
    check("rf_x31", rf[31], 64'd0);

    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rop = 2'(i % 3);
      runOp(rop, ra, rb, 5'(12 + i), refModel(rop, ra, rb), 1'b0);
    end

    // A start pulse mid-CALC must not disturb the running operation.
    runOp(2'b10, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 5'd20,
          refModel(2'b10, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210), 1'b1);
    check("rf_x21_untouched", rf[21], 64'd0);

    // Reset during CALC iteration 30 aborts without any write.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 64'd11; bus.b = 64'd13; bus.rd = 5'd10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    rwCnt = 0; doneCnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (bus.RegWrite) rwCnt++;
      if (bus.done) doneCnt++;
    end
    check("abort_regwrite", 64'(rwCnt), 64'd0);
    check("abort_done", 64'(doneCnt), 64'd0);
    check("rf_x10", rf[10], 64'd0);
    runOp(2'b00, 64'd2, 64'd2, 5'd11, 64'd4, 1'b0);
    check("rf_x11", rf[11], 64'd4);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative 64x64 multiplier in the execute path, issuing the LEGv8 MUL, SMULH and UMULH operations.
- Operands come from regfile ReadData1/ReadData2. The result drives the regfile write port (WriteData, WriteRegister, RegWrite) directly.
- Radix-2 shift-add over 64 cycles; busy tells the pipeline control to stall.

Parameters:
- WIDTH, 64, operand/result width; all values below assume 64.
- CNT_W, 7, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low 64 bits), 01 SMULH (signed high 64), 10 UMULH (unsigned high 64), 11 reserved (treated as MUL)
- a  input  64  multiplicand (ReadData1)
- b  input  64  multiplier (ReadData2)
- rd  input  5  destination register number
- busy  output  1  high from the cycle after start is accepted through the WB cycle
- done  output  1  one-cycle pulse in the WB cycle
- WriteData  output  64  result to regfile
- WriteRegister  output  5  latched rd
- RegWrite  output  1  regfile write enable

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, RegWrite=0, WriteData=0, WriteRegister=0, counter=0, accumulators=0.
- States: IDLE, CALC, FIX, WB.
- IDLE, start=1 at edge E0:
  - Latch op and rd.
  - For SMULH, latch |a| and |b| and neg = a[63]^b[63]. Otherwise latch a and b unchanged, neg=0.
  - Clear the 128-bit product and counter; go to CALC.
- CALC, per edge:
  - If multiplier LSB is 1, add the multiplicand into product[127:64] (65-bit sum, carry kept).
  - Shift the {carry, product} right by 1; shift the multiplier right by 1; counter++.
  - After the 64th iteration (edge E64), go to FIX.
- FIX (edge E65):
  - If neg, product = two's-complement negation of the 128-bit product.
  - WriteData = product[63:0] for MUL, product[127:64] for SMULH/UMULH. Go to WB.
- WB (cycle after E65): done=1, RegWrite=(rd!=31), busy=1. The regfile samples the write at edge E66. Go to IDLE at E66.
- Latency: 66 edges from accepting start to the regfile write edge. Back-to-back: a new start can be accepted at E66+1 at the earliest.
- busy: 0 in IDLE, 1 in CALC/FIX/WB.
- start while busy: ignored, with no effect on latched operands.
- start held high in IDLE after WB: treated as a new request.
- WriteData and WriteRegister hold their last values in IDLE. RegWrite is 0 in every state except WB.
- rd=31 (XZR): computation runs and done pulses, but RegWrite stays 0.
- |0x8000_0000_0000_0000| = 2^63 is represented exactly as unsigned; no overflow special case.
- Reset in any state: next edge returns to IDLE with all reset values; no write is issued even if reset lands in FIX or WB.
- Operand inputs a, b, op, rd are don't-care after the start cycle.

Decomposition:
- Package mul_pkg holds:
  - op encoding enum (OP_MUL, OP_SMULH, OP_UMULH);
  - state enum (S_IDLE, S_CALC, S_FIX, S_WB);
  - constant XZR = 5'd31.
- One sub-module, mul_shift_add_step: combinational single-iteration datapath. Inputs are the 128-bit product, 64-bit multiplicand and multiplier LSB; output is the next product.
- mul_unit holds the FSM, counter and operand/sign registers.

Test Plan:
- MUL: a=3, b=5, rd=2, start 1 cycle -> busy for 66 cycles; done and RegWrite high for exactly one cycle with WriteData=0x0F, WriteRegister=2; regfile X2 reads 0x0F afterwards.
- SMULH:
  - a=0xFFFF_FFFF_FFFF_FFFF (-1), b=1 -> WriteData=0xFFFF_FFFF_FFFF_FFFF.
  - a=b=-1 -> WriteData=0.
  - a=b=0x8000_0000_0000_0000 -> WriteData=0x4000_0000_0000_0000.
- UMULH: a=b=0xFFFF_FFFF_FFFF_FFFF -> WriteData=0xFFFF_FFFF_FFFF_FFFE; same operands with MUL -> 0x0000_0000_0000_0001.
- start pulsed at cycle 10 of CALC with different a/b/rd -> ignored; the original result and rd are written, with exactly one RegWrite pulse.
- rd=31, MUL 7*9 -> done pulses, RegWrite never asserts; regfile X31 still reads 0.
- reset asserted for one cycle during CALC (iteration 30) -> busy=0 next cycle, no RegWrite pulse; a fresh MUL 2*2 then completes with WriteData=4.
